// File: rtl/io_input_debounce.sv
// io_input_debounce
//   Two banks of slide switches, each bit synchronised, then qualified by a
//   shared sample prescaler and a per-bit stability counter. A new level is
//   accepted only after STABLE_N consecutive sample ticks that all see it.
//   A sticky event flag per bank records that any accepted bit changed.
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous, active-high; clears all state
//   raw_in0/1[9:0] unsynchronised switch banks
//   ev_ack         clears both event flags (a same-cycle update wins)
//   in_port0/1     debounced, registered banks
//   ev0/ev1        sticky change flags per bank
//   tick           one-cycle sample strobe

// Per-bit synchroniser plus stability qualifier.
module io_debounce_bit #(
  parameter int STABLE_N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic tick_i,
  output logic out_o,
  output logic upd_o   // this bit's output changes at the next edge
);
  localparam logic [3:0] CNT_MAX = 4'(STABLE_N - 1);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic [3:0] cnt_q, cnt_d;
  logic       out_q, out_d;

  always_comb begin
    s1_d  = raw_i;
    s2_d  = s1_q;
    cnt_d = cnt_q;
    out_d = out_q;
    upd_o = 1'b0;
    // Any cycle where the synced level agrees with the output restarts
    // qualification, so a glitch between ticks throws away the count.
    if (s2_q == out_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_MAX) begin
        out_d = s2_q;
        cnt_d = '0;
        upd_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;
endmodule

module io_input_debounce #(
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_N   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw_in0,
  input  logic [9:0] raw_in1,
  input  logic       ev_ack,
  output logic [9:0] in_port0,
  output logic [9:0] in_port1,
  output logic       ev0,
  output logic       ev1,
  output logic       tick
);
  localparam int          NUM_LANES = 2;
  localparam int          VEC_W     = 10;
  localparam logic [15:0] DIV_MAX   = 16'(SAMPLE_DIV - 1);

  // Sample prescaler. tick decodes the registered count, so it carries no
  // path from any input.
  logic [15:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == DIV_MAX) ? '0 : div_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  assign tick = (div_q == DIV_MAX);

  // Bit lanes: lane 0 = bank 0, lane 1 = bank 1.
  logic [NUM_LANES-1:0][VEC_W-1:0] raw;
  logic [NUM_LANES-1:0][VEC_W-1:0] deb;
  logic [NUM_LANES-1:0][VEC_W-1:0] upd;

  assign raw = {raw_in1, raw_in0};

  io_debounce_bit #(.STABLE_N(STABLE_N)) u_bit [NUM_LANES*VEC_W-1:0] (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (raw),
    .tick_i (tick),
    .out_o  (deb),
    .upd_o  (upd)
  );

  // Event flags: set on the same edge the bank updates; ack clears, but a
  // simultaneous update takes priority.
  logic [NUM_LANES-1:0] ev_q, ev_d;

  always_comb begin
    ev_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      ev_d[l] = (|upd[l]) | (ev_q[l] & ~ev_ack);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ev_q <= '0;
    else       ev_q <= ev_d;
  end

  assign in_port0 = deb[0];
  assign in_port1 = deb[1];
  assign ev0      = ev_q[0];
  assign ev1      = ev_q[1];
endmodule

// File: tb/tb_io_input_debounce.sv
module tb_io_input_debounce;
  localparam int SAMPLE_DIV = 4;
  localparam int STABLE_N   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] raw_in0, raw_in1;
  logic       ev_ack;
  logic [9:0] in_port0, in_port1;
  logic       ev0, ev1, tick;

  io_input_debounce #(.SAMPLE_DIV(SAMPLE_DIV), .STABLE_N(STABLE_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_in0  (raw_in0),
    .raw_in1  (raw_in1),
    .ev_ack   (ev_ack),
    .in_port0 (in_port0),
    .in_port1 (in_port1),
    .ev0      (ev0),
    .ev1      (ev1),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] p0;
    logic [9:0] p1;
    logic       e0;
    logic       e1;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [9:0] p0, input logic [9:0] p1,
                         input logic e0, input logic e1);
    exp_t e;
    e.p0 = p0; e.p1 = p1; e.e0 = e0; e.e1 = e1;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_in_port0"}, 32'(in_port0), 32'(e.p0));
      chk({tag, "_in_port1"}, 32'(in_port1), 32'(e.p1));
      chk({tag, "_ev0"},      32'(ev0),      32'(e.e0));
      chk({tag, "_ev1"},      32'(ev1),      32'(e.e1));
    end
  endtask

  // Wait (bounded) for either port to change; drops ev_ack on the change so
  // an ack held across the update edge does not clear the new flag.
  task automatic wait_chg(input int budget, output int lat);
    logic [9:0] p0, p1;
    p0  = in_port0;
    p1  = in_port1;
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (in_port0 !== p0 || in_port1 !== p1) begin
        lat    = i;
        ev_ack = 1'b0;
        break;
      end
    end
  endtask

  task automatic ack_pulse();
    ev_ack = 1'b1;
    @(posedge clk); #1;
    ev_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  lat;
    int  nt;
    bit  seen;
    bit  t;

    reset = 1'b1; raw_in0 = '0; raw_in1 = '0; ev_ack = 1'b0;
    #23;
    chk("rst_in_port0", 32'(in_port0), 32'h0);
    chk("rst_in_port1", 32'(in_port1), 32'h0);
    chk("rst_ev0",      32'(ev0),      32'h0);
    chk("rst_ev1",      32'(ev1),      32'h0);
    chk("rst_tick",     32'(tick),     32'h0);

    // First tick lands on edge SAMPLE_DIV-1 after release.
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("tick_phase_%0d", k), 32'(tick), 32'(k == SAMPLE_DIV - 2));
    end

    // All ones on bank 0.
    raw_in0 = 10'h3FF;
    sb_push(10'h3FF, 10'h000, 1'b1, 1'b0);
    wait_chg(2 + STABLE_N * SAMPLE_DIV, lat);
    chk("bank0_all_ones_latency_ok", 32'(lat >= 2 + (STABLE_N - 1) * SAMPLE_DIV + 1), 32'd1);
    sb_pop("bank0_all_ones");
    ack_pulse();
    chk("ack_clears_ev0", 32'(ev0), 32'h0);

    // Short pulse is rejected.
    seen = 1'b0;
    raw_in1[0] = 1'b1;
    for (int c = 0; c < 23; c++) begin
      if (c == 3) raw_in1[0] = 1'b0;
      @(posedge clk); #1;
      if (in_port1 !== 10'h0 || ev1 !== 1'b0) seen = 1'b1;
    end
    chk("short_pulse_no_change", 32'(seen), 32'h0);

    // Toggling every 5 cycles never qualifies.
    seen = 1'b0;
    for (int c = 0; c < 52; c++) begin
      if (c < 40) raw_in1[0] = ((c / 5) % 2 == 0);
      @(posedge clk); #1;
      if (in_port1 !== 10'h0 || ev1 !== 1'b0) seen = 1'b1;
    end
    chk("toggle_no_change", 32'(seen), 32'h0);

    // Set ev1, then land a bank-0 update under a held ack.
    raw_in1 = 10'h001;
    sb_push(10'h3FF, 10'h001, 1'b0, 1'b1);
    wait_chg(2 + STABLE_N * SAMPLE_DIV, lat);
    chk("bank1_bit0_timeout", 32'(lat > 0), 32'd1);
    sb_pop("bank1_bit0");

    raw_in0 = 10'h000;
    ev_ack  = 1'b1;
    sb_push(10'h000, 10'h001, 1'b1, 1'b0);
    wait_chg(2 + STABLE_N * SAMPLE_DIV, lat);
    ev_ack  = 1'b0;
    chk("ack_vs_update_timeout", 32'(lat > 0), 32'd1);
    sb_pop("ack_vs_update");
    ack_pulse();
    chk("ack_alone_ev0", 32'(ev0), 32'h0);

    // Reset partway through qualification discards the count.
    raw_in0 = 10'h020;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nt = 0;
    for (int i = 0; i < 16 && nt < 2; i++) begin
      t = tick;
      @(posedge clk); #1;
      if (t) nt++;
    end
    reset = 1'b1;
    #1;
    chk("midrst_in_port0", 32'(in_port0), 32'h0);
    chk("midrst_in_port1", 32'(in_port1), 32'h0);
    chk("midrst_ev0",      32'(ev0),      32'h0);
    chk("midrst_ev1",      32'(ev1),      32'h0);
    chk("midrst_tick",     32'(tick),     32'h0);
    @(negedge clk); reset = 1'b0;
    sb_push(10'h020, 10'h001, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 10) chk("requal_not_early", 32'(in_port0), 32'h0);
      if (k == 11) sb_pop("requal_full");
    end

    // Both banks change on the same cycle.
    ack_pulse();
    chk("pre_both_ev0", 32'(ev0), 32'h0);
    chk("pre_both_ev1", 32'(ev1), 32'h0);
    raw_in0 = 10'h2A5;
    raw_in1 = 10'h15A;
    sb_push(10'h2A5, 10'h15A, 1'b1, 1'b1);
    wait_chg(2 + STABLE_N * SAMPLE_DIV, lat);
    chk("both_banks_timeout", 32'(lat > 0), 32'd1);
    sb_pop("both_banks");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/io_input_debounce.md
IO_INPUT_DEBOUNCE -- requirements
Module: io_input_debounce

Interface
REQ-001 Parameter SAMPLE_DIV, default 50000, clk cycles per sample tick, legal range 2..65535.
REQ-002 Parameter STABLE_N, default 4, consecutive differing samples needed to accept a new level, legal range 2..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 raw_in0  input  10  asynchronous slide-switch bank 0, unsynchronised.
REQ-006 raw_in1  input  10  asynchronous slide-switch bank 1, unsynchronised.
REQ-007 ev_ack  input  1  clears both event flags; synchronous to clk.
REQ-008 in_port0  output  10  debounced bank 0, registered; drives the CPU data-memory input port 0.
REQ-009 in_port1  output  10  debounced bank 1, registered; drives the CPU data-memory input port 1.
REQ-010 ev0  output  1  sticky flag, set when any in_port0 bit changes.
REQ-011 ev1  output  1  sticky flag, set when any in_port1 bit changes.
REQ-012 tick  output  1  one-cycle sample strobe, for observation.

Function
REQ-013 Each raw bit passes through a two-flop synchroniser; sync value = second flop.
REQ-014 Prescaler: 16-bit counter 0..SAMPLE_DIV-1; wraps to 0; tick=1 exactly in the cycle the count is SAMPLE_DIV-1.
REQ-015 Per bit, 4-bit stability counter cnt; any cycle with sync==out: cnt<=0, output held.
REQ-016 Tick cycle with sync!=out and cnt<STABLE_N-1: cnt<=cnt+1, output held.
REQ-017 Tick cycle with sync!=out and cnt==STABLE_N-1: out<=sync, cnt<=0.
REQ-018 Non-tick cycle with sync!=out: cnt and out held.
REQ-019 Glitch shorter than one full tick period between mismatched ticks: the counter is cleared; no output change.
REQ-020 Bits are independent; several bits of one bank may update in the same cycle.
REQ-021 evN<=1 in the cycle after any in_portN bit changes; held until cleared.
REQ-022 ev_ack=1 with no change: ev0, ev1<=0 next cycle.
REQ-023 ev_ack=1 in the same cycle as an update of bank N: evN<=1 (set wins); the other flag clears.
REQ-024 Worst-case acceptance latency after a raw edge: 2 + STABLE_N*SAMPLE_DIV cycles; minimum: 2 + (STABLE_N-1)*SAMPLE_DIV + 1 cycles.
REQ-025 No combinational path from any input to any output.

Reset
REQ-026 reset=1 asynchronously forces synchronisers, counters, prescaler, in_port0, in_port1, ev0, ev1 and tick to 0.
REQ-027 Reset asserted mid-count discards the partial count; after release, the prescaler restarts at 0 and outputs stay 0 until a new level is accepted.
REQ-028 First tick after reset release occurs in cycle SAMPLE_DIV-1 after release (cycle 0 = first edge with reset low).

Verification (SAMPLE_DIV=4, STABLE_N=3)
REQ-029 Reset, raw_in0=10'h3FF held -> in_port0=10'h3FF and ev0=1 within 2+12 cycles; in_port1=0; ev1=0.
REQ-030 raw_in1[0] pulses high for 3 cycles, then low -> in_port1 stays 10'h000; ev1 stays 0.
REQ-031 raw_in1[0] toggles every 5 cycles for 40 cycles -> no output change; the counter never reaches 2 at a tick with a mismatch.
REQ-032 in_port0 update coincides with ev_ack=1 -> ev0=1 after the edge; ev1 cleared; next ev_ack alone -> ev0=0.
REQ-033 reset pulse while cnt=2 for raw_in0[5]=1 -> all outputs 0 at once; after release, the full 3-tick qualification is repeated before in_port0[5]=1.
REQ-034 raw_in0=10'h2A5 and raw_in1=10'h15A change on the same cycle -> both ports update on the same edge; ev0 and ev1 set together.
